// File: rtl/fifo_32x8.sv
// rtl/fifo_32x8.sv - 32x8 synchronous FIFO with registered read data; optional sticky ERR output via FIFO_32X8_ERR_EN
module fifo_32x8 (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic [7:0] data_in_i,
  input  logic       read_i,
  input  logic       write_i,
  input  logic       clear_n_i,
  output logic [7:0] data_out_o,
  output logic       f_full_n_o,
  output logic       f_empty_n_o,
`ifdef FIFO_32X8_ERR_EN
  output logic       err_o,
`endif
  output logic [4:0] use_dw_o
);

  localparam logic [5:0] FULL_COUNT = 6'd32;

  logic [7:0] mem_q [32];
  logic [4:0] wptr_q, wptr_d;
  logic [4:0] rptr_q, rptr_d;
  logic [5:0] count_q, count_d;
  logic [7:0] dout_q, dout_d;
  logic       rd_ok, wr_ok, mem_we;
`ifdef FIFO_32X8_ERR_EN
  logic       err_q, err_d;
`endif

  // Accept/decode logic and next-state for pointers, occupancy and read data
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    dout_d  = dout_q;
    mem_we  = 1'b0;
    rd_ok   = read_i && (count_q != 6'd0);
    // A read in the same cycle frees a slot, so a full FIFO can still take a write
    wr_ok   = write_i && ((count_q != FULL_COUNT) || rd_ok);
`ifdef FIFO_32X8_ERR_EN
    err_d   = err_q | (read_i && (count_q == 6'd0)) | (write_i && !wr_ok);
`endif
    if (!clear_n_i) begin
      // Flush drops every request in this cycle and leaves read data untouched
      wptr_d  = 5'd0;
      rptr_d  = 5'd0;
      count_d = 6'd0;
`ifdef FIFO_32X8_ERR_EN
      err_d   = 1'b0;
`endif
    end else begin
      if (rd_ok) begin
        dout_d = mem_q[rptr_q];
        rptr_d = rptr_q + 5'd1;
      end
      if (wr_ok) begin
        mem_we = 1'b1;
        wptr_d = wptr_q + 5'd1;
      end
      unique case ({wr_ok, rd_ok})
        2'b10:   count_d = count_q + 6'd1;
        2'b01:   count_d = count_q - 6'd1;
        default: count_d = count_q;
      endcase
    end
  end

  // State registers; reset wins over flush, which is folded into the _d values
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wptr_q  <= 5'd0;
      rptr_q  <= 5'd0;
      count_q <= 6'd0;
      dout_q  <= 8'h00;
`ifdef FIFO_32X8_ERR_EN
      err_q   <= 1'b0;
`endif
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      dout_q  <= dout_d;
`ifdef FIFO_32X8_ERR_EN
      err_q   <= err_d;
`endif
    end
  end

  // Storage array is never reset; only accepted writes update it
  always_ff @(posedge clk_i) begin
    if (!reset_i && mem_we) begin
      mem_q[wptr_q] <= data_in_i;
    end
  end

  assign data_out_o  = dout_q;
  assign f_full_n_o  = (count_q != FULL_COUNT);
  assign f_empty_n_o = (count_q != 6'd0);
  assign use_dw_o    = count_q[4:0];
`ifdef FIFO_32X8_ERR_EN
  assign err_o       = err_q;
`endif

endmodule

// File: tb/tb_fifo_32x8.sv
// tb/tb_fifo_32x8.sv - scoreboard testbench for fifo_32x8
module tb_fifo_32x8;

  logic       clk = 1'b0;
  logic       reset, read, write, clear_n;
  logic [7:0] din;
  logic [7:0] data_out;
  logic       f_full_n, f_empty_n;
  logic [4:0] use_dw;
`ifdef FIFO_32X8_ERR_EN
  logic       err;
`endif

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] exp_q [$];
  logic [7:0] last_rd;
  bit         got_rd;
  int         mcount;

  always #5 clk = ~clk;

  fifo_32x8 dut (
    .clk_i      (clk),
    .reset_i    (reset),
    .data_in_i  (din),
    .read_i     (read),
    .write_i    (write),
    .clear_n_i  (clear_n),
    .data_out_o (data_out),
    .f_full_n_o (f_full_n),
    .f_empty_n_o(f_empty_n),
`ifdef FIFO_32X8_ERR_EN
    .err_o      (err),
`endif
    .use_dw_o   (use_dw)
  );

  // Drive one cycle and advance the scoreboard; checks are done by the callers
  task automatic apply(input bit rd, input bit wr, input logic [7:0] d, input bit clr_n);
    bit rd_ok, wr_ok;
    read = rd; write = wr; din = d; clear_n = clr_n;
    got_rd = 1'b0;
    if (!clr_n) begin
      exp_q.delete();
    end else begin
      rd_ok = rd && (mcount != 0);
      wr_ok = wr && ((mcount != 32) || rd_ok);
      if (rd_ok) begin
        last_rd = exp_q.pop_front();
        got_rd = 1'b1;
      end
      if (wr_ok) exp_q.push_back(d);
    end
    mcount = exp_q.size();
    @(posedge clk); #1;
    read = 1'b0; write = 1'b0; clear_n = 1'b1;
  endtask

  task automatic test_reset;
    reset = 1'b1; read = 1'b0; write = 1'b0; clear_n = 1'b1; din = 8'h00;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    exp_q.delete(); mcount = 0; last_rd = 8'h00;
    vectors++; if (data_out !== 8'h00) begin miscompares++; $display("FAIL reset_data_out got=%h exp=00", data_out); end
    vectors++; if (f_full_n !== 1'b1) begin miscompares++; $display("FAIL reset_full_n got=%b exp=1", f_full_n); end
    vectors++; if (f_empty_n !== 1'b0) begin miscompares++; $display("FAIL reset_empty_n got=%b exp=0", f_empty_n); end
    vectors++; if (use_dw !== 5'd0) begin miscompares++; $display("FAIL reset_use_dw got=%0d exp=0", use_dw); end
`ifdef FIFO_32X8_ERR_EN
    vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL reset_err got=%b exp=0", err); end
`endif
    apply(1'b0, 1'b0, 8'h00, 1'b0);
    vectors++; if ({data_out, f_full_n, f_empty_n, use_dw} !== {8'h00, 1'b1, 1'b0, 5'd0}) begin
      miscompares++; $display("FAIL clear_after_reset got=%h/%b/%b/%0d exp=00/1/0/0", data_out, f_full_n, f_empty_n, use_dw);
    end
  endtask

  task automatic test_basic;
    logic [7:0] pat [4] = '{8'h01, 8'h02, 8'h04, 8'h08};
    for (int i = 0; i < 4; i++) apply(1'b0, 1'b1, pat[i], 1'b1);
    vectors++; if (use_dw !== 5'd4) begin miscompares++; $display("FAIL basic_use_dw got=%0d exp=4", use_dw); end
    vectors++; if (f_empty_n !== 1'b1) begin miscompares++; $display("FAIL basic_empty_n got=%b exp=1", f_empty_n); end
    for (int i = 0; i < 4; i++) begin
      apply(1'b1, 1'b0, 8'h00, 1'b1);
      vectors++; if (!got_rd || data_out !== pat[i]) begin
        miscompares++; $display("FAIL basic_read%0d got=%h exp=%h", i, data_out, pat[i]);
      end
    end
    vectors++; if (use_dw !== 5'd0 || f_empty_n !== 1'b0) begin
      miscompares++; $display("FAIL basic_drain got=%0d/%b exp=0/0", use_dw, f_empty_n);
    end
  endtask

  task automatic test_full;
    for (int i = 0; i < 32; i++) apply(1'b0, 1'b1, 8'(i), 1'b1);
    vectors++; if (f_full_n !== 1'b0 || use_dw !== 5'd0 || f_empty_n !== 1'b1) begin
      miscompares++; $display("FAIL full_flags got=%b/%0d/%b exp=0/0/1", f_full_n, use_dw, f_empty_n);
    end
    apply(1'b0, 1'b1, 8'hAA, 1'b1);
    vectors++; if (f_full_n !== 1'b0 || use_dw !== 5'd0) begin
      miscompares++; $display("FAIL full_overwrite got=%b/%0d exp=0/0", f_full_n, use_dw);
    end
`ifdef FIFO_32X8_ERR_EN
    vectors++; if (err !== 1'b1) begin miscompares++; $display("FAIL full_err got=%b exp=1", err); end
`endif
    for (int i = 0; i < 32; i++) begin
      apply(1'b1, 1'b0, 8'h00, 1'b1);
      vectors++; if (!got_rd || data_out !== last_rd || data_out !== 8'(i)) begin
        miscompares++; $display("FAIL full_read%0d got=%h exp=%h", i, data_out, 8'(i));
      end
    end
    vectors++; if (f_empty_n !== 1'b0 || f_full_n !== 1'b1) begin
      miscompares++; $display("FAIL full_drain got=%b/%b exp=0/1", f_empty_n, f_full_n);
    end
  endtask

  task automatic test_wrap;
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 20; i++) apply(1'b0, 1'b1, 8'(8'h40 + r * 20 + i), 1'b1);
      vectors++; if (use_dw !== 5'd20) begin miscompares++; $display("FAIL wrap_fill%0d got=%0d exp=20", r, use_dw); end
      for (int i = 0; i < 20; i++) begin
        apply(1'b1, 1'b0, 8'h00, 1'b1);
        vectors++; if (!got_rd || data_out !== last_rd) begin
          miscompares++; $display("FAIL wrap_read%0d_%0d got=%h exp=%h", r, i, data_out, last_rd);
        end
      end
    end
    vectors++; if (use_dw !== 5'd0 || f_empty_n !== 1'b0) begin
      miscompares++; $display("FAIL wrap_end got=%0d/%b exp=0/0", use_dw, f_empty_n);
    end
  endtask

  task automatic test_simultaneous;
    for (int i = 0; i < 32; i++) apply(1'b0, 1'b1, 8'(8'h80 + i), 1'b1);
    apply(1'b1, 1'b1, 8'hC0, 1'b1);
    vectors++; if (data_out !== 8'h80) begin miscompares++; $display("FAIL simul_full_data got=%h exp=80", data_out); end
    vectors++; if (use_dw !== 5'd0 || f_full_n !== 1'b0) begin
      miscompares++; $display("FAIL simul_full_flags got=%0d/%b exp=0/0", use_dw, f_full_n);
    end
    for (int i = 0; i < 32; i++) begin
      apply(1'b1, 1'b0, 8'h00, 1'b1);
      vectors++; if (!got_rd || data_out !== last_rd) begin
        miscompares++; $display("FAIL simul_drain%0d got=%h exp=%h", i, data_out, last_rd);
      end
    end
    vectors++; if (data_out !== 8'hC0) begin miscompares++; $display("FAIL simul_last got=%h exp=c0", data_out); end
    apply(1'b1, 1'b1, 8'h5A, 1'b1);
    vectors++; if (data_out !== 8'hC0 || use_dw !== 5'd1 || f_empty_n !== 1'b1) begin
      miscompares++; $display("FAIL simul_empty got=%h/%0d/%b exp=c0/1/1", data_out, use_dw, f_empty_n);
    end
    apply(1'b1, 1'b0, 8'h00, 1'b1);
    vectors++; if (data_out !== 8'h5A) begin miscompares++; $display("FAIL simul_empty_read got=%h exp=5a", data_out); end
  endtask

  task automatic test_clear;
    logic [7:0] held;
    for (int i = 0; i < 5; i++) apply(1'b0, 1'b1, 8'(8'h10 + i), 1'b1);
    held = last_rd;
    apply(1'b1, 1'b1, 8'hEE, 1'b0);
    vectors++; if (f_empty_n !== 1'b0 || use_dw !== 5'd0) begin
      miscompares++; $display("FAIL clear_flags got=%b/%0d exp=0/0", f_empty_n, use_dw);
    end
    vectors++; if (data_out !== held) begin miscompares++; $display("FAIL clear_hold got=%h exp=%h", data_out, held); end
    apply(1'b1, 1'b0, 8'h00, 1'b1);
    vectors++; if (data_out !== held || f_empty_n !== 1'b0) begin
      miscompares++; $display("FAIL clear_read got=%h/%b exp=%h/0", data_out, f_empty_n, held);
    end
    apply(1'b0, 1'b1, 8'h33, 1'b1);
    apply(1'b1, 1'b0, 8'h00, 1'b1);
    vectors++; if (data_out !== 8'h33) begin miscompares++; $display("FAIL clear_restart got=%h exp=33", data_out); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full();
    test_wrap();
    test_simultaneous();
    test_clear();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
